// File: rtl/cpu_pkg.sv
// Shared definitions for the P6 pipeline: reset/base addresses, the NOP
// encoding, the next-PC select encodings and the IF/ID payload layout.
package cpu_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  // Next-PC mux select, driven by control/hazard logic.
  typedef enum logic [1:0] {
    NPC_ADD4   = 2'd0,
    NPC_TARGET = 2'd1,
    NPC_REG    = 2'd2
  } npc_sel_e;

  // IF/ID payload; the valid bit is owned by the pipeline register itself.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_add8;
    logic        exc;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with flush-over-stall priority. Flush writes an
// all-zero bubble, stall holds, otherwise the payload loads with valid=1.
// Width-parameterised so it can be reused between later stages.
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Flush beats stall; a held register keeps both payload and valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (!stall) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 feedback, ROM word address,
// and the IF/ID pipeline register.
// Optional build macro FETCH_ADDR_CHECK_EN: flags misaligned or
// out-of-ROM fetch addresses as an address error and squashes the
// instruction word. Without it the error output stays 0 and out-of-range
// PCs alias through the truncated ROM index.
import cpu_pkg::*;

module fetch_stage #(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      next_pc,
  output logic [31:0]      pc_f,
  output logic [31:0]      pc_add4_f,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc_add8_d,
  output logic             valid_d,
  output logic             exc_adel_d
);

  logic        exc;
  logic        load_valid;
  if_id_t      if_id_in;
  if_id_t      if_id_out;
  logic [31:0] fetch_cnt;

  assign pc_add4_f = pc_f + 32'd4;
  assign imem_addr = IM_AW'((pc_f - IM_BASE) >> 2);

`ifdef FETCH_ADDR_CHECK_EN
  // One past the last ROM byte, widened so a ROM ending at 2^32 still compares.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd1 << (IM_AW + 2));
  assign exc = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || ({1'b0, pc_f} >= IM_END);
`else
  assign exc = 1'b0;
`endif

  // Payload captured into IF/ID; a faulting fetch carries a NOP word.
  always_comb begin
    if_id_in.instr   = exc ? INSTR_NOP : imem_rdata;
    if_id_in.pc      = pc_f;
    if_id_in.pc_add8 = pc_f + 32'd8;
    if_id_in.exc     = exc;
  end

  // PC register: follows next_pc on every unstalled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= PC_RESET;
    end else if (!stall) begin
      pc_f <= next_pc;
    end
  end

  if_id_reg #(
    .W($bits(if_id_t))
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .d     (if_id_in),
    .q     (if_id_out),
    .valid (valid_d)
  );

  assign instr_d    = if_id_out.instr;
  assign pc_d       = if_id_out.pc;
  assign pc_add8_d  = if_id_out.pc_add8;
  assign exc_adel_d = if_id_out.exc;

  // Same condition under which IF/ID loads a real instruction.
  assign load_valid = !flush && !stall;

  // Count of instructions handed to decode; debug visibility only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
    end else if (load_valid) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the P6 five-stage pipelined MIPS core: holds the PC register, produces `PC+4` for the next-PC select mux, and latches the fetched instruction into the IF/ID pipeline register. It consumes the mux output `next_pc` every unstalled cycle. It sits directly upstream of decode, between the next-PC mux and the instruction ROM. It is driven by the hazard unit's `stall` and `flush`.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000, PC value after reset.
- `IM_BASE`, 32'h0000_3000, byte address of instruction ROM word 0.
- `IM_AW`, 10, ROM word-address width (depth = 2^IM_AW words).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  hazard freeze; holds the PC and IF/ID contents.
- `flush`  in  1  writes a bubble into IF/ID.
- `next_pc`  in  32  selected next PC from the next-PC mux.
- `pc_f`  out  32  current PC register.
- `pc_add4_f`  out  32  `pc_f + 4`, fed back to the next-PC mux.
- `imem_addr`  out  IM_AW  ROM word index.
- `imem_rdata`  in  32  combinational ROM data for `imem_addr`.
- `instr_d`  out  32  IF/ID instruction.
- `pc_d`  out  32  IF/ID PC.
- `pc_add8_d`  out  32  IF/ID `PC+8` (jal/jalr link value).
- `valid_d`  out  1  IF/ID holds a real instruction (0 = bubble).
- `exc_adel_d`  out  1  fetch address error (see Configuration).

## Operation
- `pc_add4_f = pc_f + 4`, modulo 2^32, combinational.
- `imem_addr = (pc_f - IM_BASE) >> 2`, truncated to IM_AW bits, combinational.
- PC register: loads `next_pc` on each edge with `stall=0`; holds when `stall=1`.
- IF/ID update priority, highest first:
  1. `flush=1`: bubble (`instr_d=0`, `pc_d=0`, `pc_add8_d=0`, `valid_d=0`, `exc_adel_d=0`), regardless of `stall`.
  2. `stall=1`: hold all fields.
  3. Otherwise: load `{imem_rdata, pc_f, pc_f+8, 1, exc}`.
- When `flush` and `stall` are both asserted, the PC holds and IF/ID is bubbled.
- Fetched-instruction counter `fetch_cnt` (internal, 32 bits): increments on every IF/ID load with `valid=1` and wraps to 0. It is readable in simulation only.
- No FSM beyond the PC and IF/ID registers. `0x00000000` is the canonical NOP and bubble encoding.

## Timing
- Reset values (asynchronous, effective while `reset=1`):
  - `pc_f=PC_RESET`, `pc_add4_f=PC_RESET+4`.
  - IF/ID fields are all 0, `valid_d=0`, `fetch_cnt=0`.
- Fetch latency is 1 cycle: the instruction at `pc_f` during cycle n appears on `instr_d` in cycle n+1.
- First edge after reset release: `instr_d` = ROM[word 0], `pc_d=PC_RESET`, `pc_f=next_pc`.
- Reset asserted mid-stall or mid-flush: the reset values win immediately. The stall and flush inputs are ignored until reset is released.
- `next_pc` is sampled only on unstalled edges. Changes to it during a stall have no effect.
- PC wrap: `pc_f=32'hFFFF_FFFC` gives `pc_add4_f=0` and `pc_add8_d=4`, with no error flagged unless the check is enabled.

## Configuration
- `FETCH_ADDR_CHECK_EN` defined:
  - `exc` is set when `pc_f[1:0]!=0`, or when `pc_f` is outside `[IM_BASE, IM_BASE + 4*2^IM_AW)`.
  - On `exc`, IF/ID loads `instr_d=0`, `exc_adel_d=1`, `valid_d=1`, and `pc_d`=the faulting PC.
- `FETCH_ADDR_CHECK_EN` undefined:
  - `exc_adel_d` is tied to 0 and the ROM data is passed unchecked.
  - Out-of-range PCs alias via truncation of `imem_addr`.

## Structure
- Shared package `cpu_pkg`:
  - `PC_RESET_DEFAULT`, `IM_BASE_DEFAULT`, `INSTR_NOP=32'h0`.
  - The next-PC select encodings (0 = PC+4, 1 = branch/jump target, 2 = register target), for use by the control and hazard units.
- One sub-module: `if_id_reg`. It is the flush/stall-priority pipeline register, parameterised by payload width, and is reused later for ID/EX.
- The PC register and adders live in `fetch_stage`.

## Test plan
- Reset then release with `next_pc = pc_add4_f` looped back, ROM = 0x11, 0x22, 0x33… → `pc_d` sequence 0x3000, 0x3004, 0x3008 and `instr_d` sequence 0x11, 0x22, 0x33, each one cycle behind `pc_f`.
- `stall=1` for 3 cycles at PC 0x3008 while `next_pc` changes → `pc_f` stays 0x3008 and `instr_d` holds its value. After release, `next_pc` is loaded and `fetch_cnt` rises by exactly 1 per unstalled edge.
- `flush=1` alone → next cycle `valid_d=0`, `instr_d=0`, and the PC advances. `flush=1` with `stall=1` → bubble in IF/ID and the PC is held.
- `next_pc=0x3400` on a branch edge → next cycle `pc_f=0x3400` and `pc_add4_f=0x3404`. The following IF/ID has `pc_d=0x3400` and `pc_add8_d=0x3408`.
- Assert `reset` asynchronously mid-cycle during a stall → `pc_f=0x3000` and `valid_d=0` immediately, before the next clock edge.
- With `FETCH_ADDR_CHECK_EN` defined, `next_pc=0x3002` → IF/ID shows `exc_adel_d=1`, `instr_d=0`, `pc_d=0x3002`. `next_pc=0x4000` with `IM_AW=10` → `exc_adel_d=1`.
